pipeline_wb_stage: RTL and testbench

PIPELINE_WB_STAGE -- requirements
Module: pipeline_wb_stage

---
 rtl/pipeline_wb_pkg.sv | 36 +++
 rtl/pipeline_wb_if.sv | 41 ++++
 rtl/pipeline_wb_entry.sv | 20 ++
 rtl/pipeline_wb_stage.sv | 147 ++++++++++++++
 tb/tb_pipeline_wb_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_wb_pkg.sv
// Shared definitions for the MEM->WB pipeline register: WB control bit positions,
// the entry record layout and the buffer occupancy encoding.
package pipeline_wb_pkg;

  localparam int unsigned WB_W = 4;

  // Bit positions inside the 4-bit WB control field {RegWrite, MemtoReg, PCtoReg, Halt}
  localparam int unsigned RW  = 3;
  localparam int unsigned M2R = 2;
  localparam int unsigned P2R = 1;
  localparam int unsigned HLT = 0;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_W_DEF  = 4;

  typedef logic [WB_W-1:0] wb_t;

  // Entry record at the default field widths; the stage builds the same layout at its own widths.
  typedef struct packed {
    wb_t                   wb;
    logic [DATA_W_DEF-1:0] reg_data;
    logic [DATA_W_DEF-1:0] dmem;
    logic [REG_W_DEF-1:0]  dst_reg;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic int unsigned entry_width(int unsigned data_w, int unsigned reg_w);
    return WB_W + 2 * data_w + reg_w;
  endfunction

endpackage

// File: rtl/pipeline_wb_if.sv
// Handshake and payload bundle between MEM, the write-back stage and the register-file side.
interface pipeline_wb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [3:0]        WB;
  logic [DATA_W-1:0] reg_data_in;
  logic [DATA_W-1:0] dmem_in;
  logic [REG_W-1:0]  DstReg_in;

  logic              out_valid;
  logic              out_ready;
  logic              RegWrite;
  logic              MemtoReg;
  logic              PCtoReg;
  logic              Halt;
  logic [DATA_W-1:0] reg_data_out;
  logic [DATA_W-1:0] dmem_out;
  logic [REG_W-1:0]  DstReg_out;

  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, flush, WB, reg_data_in, dmem_in, DstReg_in, out_ready,
    input  in_ready, out_valid, RegWrite, MemtoReg, PCtoReg, Halt,
    input  reg_data_out, dmem_out, DstReg_out, halted, stall_cnt
  );

  modport slave (
    input  in_valid, flush, WB, reg_data_in, dmem_in, DstReg_in, out_ready,
    output in_ready, out_valid, RegWrite, MemtoReg, PCtoReg, Halt,
    output reg_data_out, dmem_out, DstReg_out, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_wb_entry.sv
// One buffer slot of the write-back stage: a load-enabled register cleared by reset.
module pipeline_wb_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= '0;
    end else if (we_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipeline_wb_stage.sv
// MEM->WB pipeline stage with valid/ready flow control, flush, sticky halt and stall counter.
// Define PIPELINE_WB_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipeline_wb_stage
  import pipeline_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipeline_wb_if.slave wb_io
);

  typedef struct packed {
    wb_t               wb;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] dmem;
    logic [REG_W-1:0]  dst_reg;
  } slot_t;

  localparam int unsigned EntryW = entry_width(DATA_W, REG_W);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  slot_t in_entry, main_d, main_q, skid_q;
  logic  main_we;
  logic  out_valid, in_ready, in_xfer, out_xfer;

  assign in_entry = '{wb:       wb_io.WB,
                      reg_data: wb_io.reg_data_in,
                      dmem:     wb_io.dmem_in,
                      dst_reg:  wb_io.DstReg_in};

  assign out_valid = (state_q != StEmpty);

`ifdef PIPELINE_WB_SKID_EN
  logic skid_we;
  // Depends only on flops, so out_ready never reaches in_ready combinationally.
  assign in_ready = ~rst & (state_q != StFull) & ~halted_q;
`else
  assign in_ready = ~rst & (~out_valid | wb_io.out_ready) & ~halted_q;
`endif

  assign in_xfer  = wb_io.in_valid & in_ready;
  assign out_xfer = out_valid & wb_io.out_ready;

  always_comb begin
    state_d = state_q;
    main_we = 1'b0;
    main_d  = in_entry;
`ifdef PIPELINE_WB_SKID_EN
    skid_we = 1'b0;
`endif
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_we = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_we = 1'b1;
`ifdef PIPELINE_WB_SKID_EN
        end else if (in_xfer) begin
          skid_we = 1'b1;
          state_d = StFull;
`endif
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          main_we = 1'b1;
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (wb_io.flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    halted_d = halted_q | (out_xfer & ~wb_io.flush & main_q.wb[HLT]);
    stall_d  = stall_q;
    if (out_valid && !wb_io.out_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  pipeline_wb_entry #(
    .W (EntryW)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .we_i (main_we),
    .d_i  (main_d),
    .q_o  (main_q)
  );

`ifdef PIPELINE_WB_SKID_EN
  pipeline_wb_entry #(
    .W (EntryW)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .we_i (skid_we),
    .d_i  (in_entry),
    .q_o  (skid_q)
  );
`else
  assign skid_q = '0;
`endif

  // Every head-entry output is gated so a bubble presents all zeros.
  assign wb_io.in_ready     = in_ready;
  assign wb_io.out_valid    = out_valid;
  assign wb_io.RegWrite     = out_valid & main_q.wb[RW];
  assign wb_io.MemtoReg     = out_valid & main_q.wb[M2R];
  assign wb_io.PCtoReg      = out_valid & main_q.wb[P2R];
  assign wb_io.Halt         = out_valid & main_q.wb[HLT];
  assign wb_io.reg_data_out = out_valid ? main_q.reg_data : '0;
  assign wb_io.dmem_out     = out_valid ? main_q.dmem : '0;
  assign wb_io.DstReg_out   = out_valid ? main_q.dst_reg : '0;
  assign wb_io.halted       = halted_q;
  assign wb_io.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Self-checking bench for pipeline_wb_stage: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_pipeline_wb_stage;
  import pipeline_wb_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned GW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned StallMax = (1 << CW) - 1;
`ifdef PIPELINE_WB_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_wb_if #(.DATA_W(DW), .REG_W(GW), .CNT_W(CW)) wbif ();

  pipeline_wb_stage #(
    .DATA_W (DW),
    .REG_W  (GW),
    .CNT_W  (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_io (wbif)
  );

  entry_t      mq[$];
  bit          m_halted;
  int unsigned m_stall;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic        iv;
    logic [3:0]  wb;
    logic [15:0] rd;
    logic [15:0] dm;
    logic [3:0]  dst;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [3:0]  e_ctrl;
    logic [15:0] e_rd;
    logic [15:0] e_dm;
    logic [3:0]  e_dst;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (rst || m_halted) return 1'b0;
    if (Cap == 2) return mq.size() < 2;
    return (mq.size() == 0) || wbif.out_ready;
  endfunction

  task automatic check_all();
    entry_t h;
    bit v;
    h = '0;
    v = mq.size() > 0;
    if (v) h = mq[0];
    chk("out_valid", wbif.out_valid, v);
    chk("in_ready", wbif.in_ready, m_ready());
    chk("ctrl", {wbif.RegWrite, wbif.MemtoReg, wbif.PCtoReg, wbif.Halt}, h.wb);
    chk("reg_data_out", wbif.reg_data_out, h.reg_data);
    chk("dmem_out", wbif.dmem_out, h.dmem);
    chk("DstReg_out", wbif.DstReg_out, h.dst_reg);
    chk("halted", wbif.halted, m_halted);
    chk("stall_cnt", wbif.stall_cnt, m_stall);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit rdy, v, ix, ox;
    entry_t e;
    rdy = m_ready();
    v   = mq.size() > 0;
    ix  = wbif.in_valid && rdy;
    ox  = v && wbif.out_ready;
    if (v && !wbif.out_ready && m_stall < StallMax) m_stall++;
    if (wbif.flush) begin
      mq.delete();
    end else begin
      if (ox) begin
        if (mq[0].wb[HLT]) m_halted = 1'b1;
        void'(mq.pop_front());
      end
      if (ix) begin
        e.wb = wbif.WB; e.reg_data = wbif.reg_data_in;
        e.dmem = wbif.dmem_in; e.dst_reg = wbif.DstReg_in;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic fl, input logic [3:0] wb,
                       input logic [15:0] rd, input logic [15:0] dm, input logic [3:0] dst,
                       input logic ordy);
    wbif.in_valid = iv; wbif.flush = fl; wbif.WB = wb;
    wbif.reg_data_in = rd; wbif.dmem_in = dm; wbif.DstReg_in = dst;
    wbif.out_ready = ordy;
  endtask

  task automatic cycle(input logic iv, input logic fl, input logic [3:0] wb,
                       input logic [15:0] rd, input logic [15:0] dm, input logic [3:0] dst,
                       input logic ordy);
    @(negedge clk);
    drive(iv, fl, wb, rd, dm, dst, ordy);
    #1;
    check_all();
    model_step();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
    rst = 1'b1;
    mq.delete(); m_halted = 1'b0; m_stall = 0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    //           iv  wb       rd        dm        dst   ordy | ov  ir  ctrl     rd        dm        dst
    tbl[0] = '{1'b1, 4'b1000, 16'h1234, 16'h0000, 4'h5, 1'b1, 1'b0, 1'b1, 4'b0000, 16'h0000, 16'h0000, 4'h0};
    tbl[1] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 4'b1000, 16'h1234, 16'h0000, 4'h5};
    tbl[2] = '{1'b1, 4'b0100, 16'h0000, 16'hBEEF, 4'h3, 1'b1, 1'b0, 1'b1, 4'b0000, 16'h0000, 16'h0000, 4'h0};
    tbl[3] = '{1'b1, 4'b0010, 16'hAAAA, 16'h0000, 4'h7, 1'b1, 1'b1, 1'b1, 4'b0100, 16'h0000, 16'hBEEF, 4'h3};
    tbl[4] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0010, 16'hAAAA, 16'h0000, 4'h7};
    tbl[5] = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 4'b0000, 16'h0000, 16'h0000, 4'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
    do_reset();

    // Vector table: single-entry latency, back-to-back replace in ONE, drain.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, 1'b0, tbl[i].wb, tbl[i].rd, tbl[i].dm, tbl[i].dst, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d.out_valid", i), wbif.out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d.in_ready", i), wbif.in_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d.ctrl", i),
          {wbif.RegWrite, wbif.MemtoReg, wbif.PCtoReg, wbif.Halt}, tbl[i].e_ctrl);
      chk($sformatf("tbl%0d.reg_data_out", i), wbif.reg_data_out, tbl[i].e_rd);
      chk($sformatf("tbl%0d.dmem_out", i), wbif.dmem_out, tbl[i].e_dm);
      chk($sformatf("tbl%0d.DstReg_out", i), wbif.DstReg_out, tbl[i].e_dst);
      model_step();
    end

    // Backpressure: A and B offered while blocked, then drained in order.
    cycle(1'b1, 1'b0, 4'b1000, 16'h1111, 16'h0, 4'h1, 1'b0);
    cycle(1'b1, 1'b0, 4'b1100, 16'h2222, 16'h0, 4'h2, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("in_ready_blocked", wbif.in_ready, 1'b0);
    chk("stall_counting", wbif.stall_cnt, 3);
    idle(1'b1);
    chk("drain_first_rd", wbif.reg_data_out, 16'h1111);
    idle(1'b1);
    chk("drain_second_valid", wbif.out_valid, Cap == 2);
    idle(1'b1);
    chk("stall_hold", wbif.stall_cnt, 4);

    // Flush while holding entries, with C offered in the same cycle.
    cycle(1'b1, 1'b0, 4'b1000, 16'h3333, 16'h0, 4'h3, 1'b0);
    cycle(1'b1, 1'b0, 4'b1000, 16'h4444, 16'h0, 4'h4, 1'b0);
    cycle(1'b1, 1'b1, 4'b1110, 16'hCCCC, 16'hCCCC, 4'hC, 1'b0);
    idle(1'b1);
    chk("flush_out_valid", wbif.out_valid, 1'b0);
    chk("flush_ctrl", {wbif.RegWrite, wbif.MemtoReg, wbif.PCtoReg, wbif.Halt}, 4'h0);
    idle(1'b1);

    // Stall counter saturation.
    do_reset();
    cycle(1'b1, 1'b0, 4'b1000, 16'h5555, 16'h0, 4'h5, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("stall_saturated", wbif.stall_cnt, 4'hF);
    idle(1'b1);
    idle(1'b1);

    // Halt: consumed Halt entry locks the input side until reset.
    do_reset();
    cycle(1'b1, 1'b0, 4'b0001, 16'h0BAD, 16'h0, 4'h0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 1'b0, 4'b1000, 16'h6666, 16'h0, 4'h6, 1'b1);
    chk("halted_set", wbif.halted, 1'b1);
    chk("halted_in_ready", wbif.in_ready, 1'b0);
    cycle(1'b1, 1'b1, 4'b1000, 16'h7777, 16'h0, 4'h7, 1'b1);
    idle(1'b1);
    chk("halted_after_flush", wbif.halted, 1'b1);
    chk("halted_no_output", wbif.out_valid, 1'b0);
    do_reset();
    chk("halted_cleared", wbif.halted, 1'b0);

    // Asynchronous reset in the middle of a cycle with entries held.
    cycle(1'b1, 1'b0, 4'b1000, 16'h8888, 16'h0, 4'h8, 1'b0);
    cycle(1'b1, 1'b0, 4'b0100, 16'h9999, 16'h0, 4'h9, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0);
    #3;
    rst = 1'b1;
    mq.delete(); m_halted = 1'b0; m_stall = 0;
    #1;
    check_all();
    chk("async_rst_out_valid", wbif.out_valid, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      cycle(r[0], (r[7:4] == 4'h0), {r[10:8], 1'b0}, $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 16'hFFFF), r[15:12], r[1] | r[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
